// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR family: mode selectors and default
// maximal-length tap masks for widths 2..32.
package lfsr_pkg;

   localparam int LFSR_FIBONACCI = 0;
   localparam int LFSR_GALOIS    = 1;
   localparam int LFSR_MIN_WIDTH = 2;
   localparam int LFSR_MAX_WIDTH = 64;

   // Bit n-1 set means tap n of the characteristic polynomial.
   localparam logic [31:0] LFSR_DEFAULT_TAPS [2:32] = '{
      32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
      32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
      32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
      32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
      32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
      32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
      32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
      32'h2000_0029, 32'h4800_0000, 32'h8020_0003
   };

   function automatic logic [63:0] lfsr_default_taps(input int width);
      logic [63:0] taps;
      taps = '0;
      if (width >= 2 && width <= 32) begin
         taps = {32'h0, LFSR_DEFAULT_TAPS[width]};
      end
      return taps;
   endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and observation bundle of the LFSR generator.
interface lfsr_gen_if #(
   parameter int WIDTH = 8
);
   logic             CE;
   logic             LOAD;
   logic [WIDTH-1:0] LOAD_VALUE;
   logic [WIDTH-1:0] O;
   logic             WRAP;
   logic             LOCKUP;

   modport master (
      output CE, LOAD, LOAD_VALUE,
      input  O, WRAP, LOCKUP
   );

   modport slave (
      input  CE, LOAD, LOAD_VALUE,
      output O, WRAP, LOCKUP
   );
endinterface

// File: rtl/lfsr_next.sv
// Combinational single-step of an LFSR in Fibonacci or Galois form, with
// all-zero lockup substitution by SEED. Shared with the scrambler.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
   parameter logic [WIDTH-1:0] SEED   = 8'h01,
   parameter int               GALOIS = LFSR_FIBONACCI
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] state_next,
   output logic             zero_hit
);

   logic [WIDTH-1:0] step;

   generate
      if (GALOIS == LFSR_GALOIS) begin : g_galois
         logic msb;
         assign msb     = state[WIDTH-1];
         assign step[0] = msb;
         // The top tap bit has no destination in this form and is ignored.
         for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
            assign step[gi] = state[gi-1] ^ (TAPS[gi-1] & msb);
         end
      end else begin : g_fibonacci
         assign step = {state[WIDTH-2:0], ^(state & TAPS)};
      end
   endgenerate

   assign zero_hit   = (state == '0);
   assign state_next = zero_hit ? SEED : step;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator: state/start/WRAP/LOCKUP registers with
// RESET > LOAD > CE > hold priority around the lfsr_next step.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
   parameter logic [WIDTH-1:0] SEED   = 8'h01,
   parameter int               GALOIS = LFSR_FIBONACCI
) (
   input logic       CLK,
   input logic       RESET,
   lfsr_gen_if.slave bus
);

   generate
      if (SEED == '0 || WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_cfg
         $error("lfsr_gen: SEED must be non-zero and WIDTH within 2..64");
      end
   endgenerate

   logic [WIDTH-1:0] state_reg, state_next;
   logic [WIDTH-1:0] start_reg, start_next;
   logic             wrap_reg, wrap_next;
   logic             lockup_reg, lockup_next;
   logic [WIDTH-1:0] step_value;
   logic             zero_hit;

   lfsr_next #(
      .WIDTH  (WIDTH),
      .TAPS   (TAPS),
      .SEED   (SEED),
      .GALOIS (GALOIS)
   ) u_next (
      .state      (state_reg),
      .state_next (step_value),
      .zero_hit   (zero_hit)
   );

   always_comb begin
      state_next  = state_reg;
      start_next  = start_reg;
      wrap_next   = 1'b0;
      lockup_next = lockup_reg;
      if (bus.LOAD) begin
         // An all-zero load would lock the register, so restart from SEED instead.
         if (bus.LOAD_VALUE != '0) begin
            state_next  = bus.LOAD_VALUE;
            start_next  = bus.LOAD_VALUE;
            lockup_next = 1'b0;
         end else begin
            state_next  = SEED;
            start_next  = SEED;
            lockup_next = 1'b1;
         end
      end else if (bus.CE) begin
         state_next = step_value;
         wrap_next  = (step_value == start_reg);
         if (zero_hit) begin
            lockup_next = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg  <= SEED;
         start_reg  <= SEED;
         wrap_reg   <= 1'b0;
         lockup_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         start_reg  <= start_next;
         wrap_reg   <= wrap_next;
         lockup_reg <= lockup_next;
      end
   end

   assign bus.O      = state_reg;
   assign bus.WRAP   = wrap_reg;
   assign bus.LOCKUP = lockup_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a Fibonacci 8-bit and a Galois 4-bit
// instance driven from vector tables and long period runs.
module tb_lfsr_gen;
   import lfsr_pkg::*;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   lfsr_gen_if #(.WIDTH(8)) fib_if ();
   lfsr_gen_if #(.WIDTH(4)) gal_if ();

   lfsr_gen #(
      .WIDTH  (8),
      .TAPS   (8'hB8),
      .SEED   (8'h01),
      .GALOIS (LFSR_FIBONACCI)
   ) u_fib (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (fib_if)
   );

   lfsr_gen #(
      .WIDTH  (4),
      .TAPS   (4'h1),
      .SEED   (4'h1),
      .GALOIS (LFSR_GALOIS)
   ) u_gal (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (gal_if)
   );

   typedef struct packed {
      logic [7:0] o;
      logic       wrap;
      logic       lock;
   } exp_t;

   typedef struct {
      bit         rst;
      bit         ce;
      bit         load;
      logic [7:0] lv;
      logic [7:0] o;
      bit         wrap;
      bit         lock;
   } vec_t;

   exp_t sb_q [$];
   vec_t vecs [16];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference steps written directly from the polynomial definitions.
   function automatic logic [7:0] fib_model(input logic [7:0] s);
      logic fb;
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      return {s[6:0], fb};
   endfunction

   function automatic logic [3:0] gal_model(input logic [3:0] s);
      return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
   endfunction

   task automatic fib_cycle(input bit rst, input bit ce, input bit load, input logic [7:0] lv,
                            input logic [7:0] eo, input bit ew, input bit el, input string tag);
      exp_t e;
      RESET             = rst;
      fib_if.CE         = ce;
      fib_if.LOAD       = load;
      fib_if.LOAD_VALUE = lv;
      e = '{o: eo, wrap: ew, lock: el};
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard"}, 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, " O"}, 64'(fib_if.O), 64'(e.o));
         check({tag, " WRAP"}, 64'(fib_if.WRAP), 64'(e.wrap));
         check({tag, " LOCKUP"}, 64'(fib_if.LOCKUP), 64'(e.lock));
      end
      $display("fib %s rst=%0b ce=%0b load=%0b lv=%02h -> O=%02h WRAP=%0b LOCKUP=%0b",
               tag, rst, ce, load, lv, fib_if.O, fib_if.WRAP, fib_if.LOCKUP);
   endtask

   task automatic gal_cycle(input bit rst, input bit ce, input logic [3:0] eo,
                            input bit ew, input string tag);
      exp_t e;
      RESET             = rst;
      gal_if.CE         = ce;
      gal_if.LOAD       = 1'b0;
      gal_if.LOAD_VALUE = 4'h0;
      fib_if.CE         = 1'b0;
      fib_if.LOAD       = 1'b0;
      e = '{o: {4'h0, eo}, wrap: ew, lock: 1'b0};
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard"}, 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, " O"}, 64'(gal_if.O), 64'(e.o));
         check({tag, " WRAP"}, 64'(gal_if.WRAP), 64'(e.wrap));
         check({tag, " LOCKUP"}, 64'(gal_if.LOCKUP), 64'(e.lock));
      end
      $display("gal %s rst=%0b ce=%0b -> O=%01h WRAP=%0b LOCKUP=%0b",
               tag, rst, ce, gal_if.O, gal_if.WRAP, gal_if.LOCKUP);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] m;
      logic [3:0] g;

      RESET             = 1'b1;
      fib_if.CE         = 1'b0;
      fib_if.LOAD       = 1'b0;
      fib_if.LOAD_VALUE = 8'h00;
      gal_if.CE         = 1'b0;
      gal_if.LOAD       = 1'b0;
      gal_if.LOAD_VALUE = 4'h0;

      //          rst ce load lv     O      wrap lock
      vecs[0]  = '{1, 0, 0, 8'h00, 8'h01, 0, 0};
      vecs[1]  = '{0, 1, 0, 8'h00, 8'h02, 0, 0};
      vecs[2]  = '{0, 1, 0, 8'h00, 8'h04, 0, 0};
      vecs[3]  = '{0, 0, 0, 8'h00, 8'h04, 0, 0};
      vecs[4]  = '{0, 0, 0, 8'h00, 8'h04, 0, 0};
      vecs[5]  = '{0, 1, 0, 8'h00, 8'h08, 0, 0};
      vecs[6]  = '{0, 1, 0, 8'h00, 8'h11, 0, 0};
      vecs[7]  = '{1, 1, 0, 8'h00, 8'h01, 0, 0};
      vecs[8]  = '{0, 1, 0, 8'h00, 8'h02, 0, 0};
      vecs[9]  = '{0, 1, 1, 8'h5A, 8'h5A, 0, 0};
      vecs[10] = '{0, 1, 1, 8'h00, 8'h01, 0, 1};
      vecs[11] = '{0, 1, 0, 8'h00, 8'h02, 0, 1};
      vecs[12] = '{0, 1, 0, 8'h00, 8'h04, 0, 1};
      vecs[13] = '{0, 0, 1, 8'h5A, 8'h5A, 0, 0};
      vecs[14] = '{0, 0, 1, 8'h00, 8'h01, 0, 1};
      vecs[15] = '{1, 0, 0, 8'h00, 8'h01, 0, 0};

      for (int i = 0; i < 16; i++) begin
         fib_cycle(vecs[i].rst, vecs[i].ce, vecs[i].load, vecs[i].lv,
                   vecs[i].o, vecs[i].wrap, vecs[i].lock, $sformatf("vec%0d", i));
      end

      // Full period from SEED: WRAP exactly on the 255th advance, back at 01.
      m = 8'h01;
      for (int i = 1; i <= 255; i++) begin
         m = fib_model(m);
         fib_cycle(0, 1, 0, 8'h00, m, (i == 255), 0, $sformatf("seed_run%0d", i));
      end
      check("seed_run end O", 64'(fib_if.O), 64'h01);
      m = fib_model(m);
      fib_cycle(0, 1, 0, 8'h00, m, 0, 0, "after_wrap");
      fib_cycle(0, 0, 0, 8'h00, m, 0, 0, "idle_gap");

      // Load with CE high: no advance, then full period back to 5A.
      fib_cycle(0, 1, 1, 8'h5A, 8'h5A, 0, 0, "load5A");
      m = 8'h5A;
      for (int i = 1; i <= 255; i++) begin
         m = fib_model(m);
         fib_cycle(0, 1, 0, 8'h00, m, (i == 255), 0, $sformatf("load_run%0d", i));
      end
      check("load_run end O", 64'(fib_if.O), 64'h5A);

      // Galois x^4+x+1: hand sequence then two full periods.
      gal_cycle(1, 0, 4'h1, 0, "greset");
      gal_cycle(0, 1, 4'h2, 0, "g1");
      gal_cycle(0, 1, 4'h4, 0, "g2");
      gal_cycle(0, 1, 4'h8, 0, "g3");
      gal_cycle(0, 1, 4'h3, 0, "g4");
      g = 4'h3;
      for (int i = 5; i <= 30; i++) begin
         g = gal_model(g);
         gal_cycle(0, 1, g, (i % 15 == 0), $sformatf("g%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
